// File: rtl/ps2_key_assembler_if.sv
// ps2_key_assembler_if: keyboard pin inputs and the assembled key event outputs.
interface ps2_key_assembler_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [64:0] ps2_key;
    logic        key_strobe;
    logic        rx_err;
    modport master (output ps2_clk, ps2_data, input ps2_key, key_strobe, rx_err);
    modport slave  (input ps2_clk, ps2_data, output ps2_key, key_strobe, rx_err);
endinterface

// File: rtl/ps2_key_assembler.sv
// ps2_key_assembler: filtered PS/2 frame receiver feeding a scan-code sequence
// grouper that emits one 65-bit toggle-flagged event per completed key sequence.
module ps2_key_assembler #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input logic clk_sys,
    input logic RESET_N,
    ps2_key_assembler_if.slave bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, EXT, BRK, EXTBRK, PRNMK, PRNMK2, PRNBK, PRNBK2, PRNBK3, PAUSE
    } state_t;

    logic [1:0]    r_sync [2];
    logic [FW-1:0] r_fcnt [2];
    logic [1:0]    r_filt;
    logic          r_clk_prev;
    logic [3:0]    r_bit_cnt;
    logic [8:0]    r_sr;
    logic [TW-1:0] r_to_cnt;
    logic          r_valid;
    logic          r_err;
    state_t        r_state;
    logic [63:0]   r_buf;
    logic [2:0]    r_rem;
    logic [64:0]   r_key;
    logic          r_strobe;
    logic [1:0]    w_raw;
    logic          w_fall;
    logic          w_dat;
    logic [7:0]    w_byte;
    logic [63:0]   w_shift;
    state_t        w_state_n;
    logic [63:0]   w_buf_n;
    logic [2:0]    w_rem_n;
    logic          w_emit;

    assign w_raw   = {bus.ps2_data, bus.ps2_clk};
    assign w_fall  = r_clk_prev & ~r_filt[0];
    assign w_dat   = r_filt[1];
    assign w_byte  = r_sr[7:0];
    assign w_shift = {r_buf[55:0], w_byte};

    // Each line only changes its filtered level after FILTER consecutive disagreeing samples
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= 2'b11;
                r_fcnt[i] <= '0;
            end
            r_filt     <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_sync[i] <= {r_sync[i][0], w_raw[i]};
                if (r_sync[i][1] == r_filt[i]) r_fcnt[i] <= '0;
                else if (r_fcnt[i] == FW'(FILTER - 1)) begin
                    r_filt[i] <= r_sync[i][1];
                    r_fcnt[i] <= '0;
                end else r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
            r_clk_prev <= r_filt[0];
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_bit_cnt <= '0;
            r_sr      <= '0;
            r_to_cnt  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (w_dat) r_err <= 1'b1;
                    else r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= '0;
                    if (w_dat && ^r_sr) r_valid <= 1'b1;
                    else r_err <= 1'b1;
                end else begin
                    r_sr      <= {w_dat, r_sr[8:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (r_to_cnt != TW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt == TW'(TIMEOUT - 1) && r_bit_cnt != 4'd0) begin
                    r_bit_cnt <= '0;
                    r_err     <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= IDLE;
            r_buf    <= '0;
            r_rem    <= '0;
            r_key    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_buf    <= w_buf_n;
            r_rem    <= w_rem_n;
            r_strobe <= w_emit;
            if (w_emit) r_key <= {~r_key[64], w_shift};
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_buf_n   = r_buf;
        w_rem_n   = r_rem;
        w_emit    = 1'b0;
        if (r_err) begin
            w_state_n = IDLE;
            w_buf_n   = '0;
        end else if (r_valid) begin
            w_buf_n = w_shift;
            case (r_state)
                IDLE: begin
                    if (w_byte == 8'hE0) w_state_n = EXT;
                    else if (w_byte == 8'hF0) w_state_n = BRK;
                    else if (w_byte == 8'hE1) begin
                        w_state_n = PAUSE;
                        w_rem_n   = 3'd7;
                    end else if (w_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) w_buf_n = '0;
                    else w_emit = 1'b1;
                end
                EXT:    if (w_byte == 8'hF0) w_state_n = EXTBRK; else if (w_byte == 8'h12) w_state_n = PRNMK; else w_emit = 1'b1;
                EXTBRK: if (w_byte == 8'h7C) w_state_n = PRNBK; else w_emit = 1'b1;
                PRNMK:  if (w_byte == 8'hE0) w_state_n = PRNMK2; else w_emit = 1'b1;
                PRNBK:  if (w_byte == 8'hE0) w_state_n = PRNBK2; else w_emit = 1'b1;
                PRNBK2: if (w_byte == 8'hF0) w_state_n = PRNBK3; else w_emit = 1'b1;
                PAUSE: begin
                    w_rem_n = r_rem - 1'b1;
                    w_emit  = (r_rem == 3'd1);
                end
                default: w_emit = 1'b1;
            endcase
            if (w_emit) begin
                w_state_n = IDLE;
                w_buf_n   = '0;
            end
        end
    end

    assign bus.ps2_key    = r_key;
    assign bus.key_strobe = r_strobe;
    assign bus.rx_err     = r_err;
endmodule

// File: tb/tb_ps2_key_assembler.sv
// tb_ps2_key_assembler: directed PS/2 frames with hand-computed event words,
// checked by immediate assertions.
module tb_ps2_key_assembler;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_strobe = 0;
    int   n_err = 0;
    int   n_double = 0;
    logic prev_strobe = 1'b0;

    ps2_key_assembler_if bus ();

    ps2_key_assembler #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk),
        .RESET_N(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.key_strobe) n_strobe++;
        if (bus.rx_err) n_err++;
        if (bus.key_strobe && prev_strobe) n_double++;
        prev_strobe = bus.key_strobe;
    end

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = f[i];
            cycles(HALF);
            bus.ps2_clk = 1'b0;
            cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        cycles(30);
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        cycles(5);
        check("reset_key", bus.ps2_key, 65'h0);
        check("reset_strobe", {64'h0, bus.key_strobe}, 65'h0);
        check("reset_err", {64'h0, bus.rx_err}, 65'h0);
        rst_n = 1'b1;
        cycles(20);

        send(8'h1C);
        check("make_key", bus.ps2_key, {1'b1, 64'h1C});
        check("make_cnt", 65'(n_strobe), 65'd1);
        send(8'hF0); send(8'h1C);
        check("break_key", bus.ps2_key, {1'b0, 64'hF01C});
        check("break_cnt", 65'(n_strobe), 65'd2);

        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_break", bus.ps2_key, {1'b1, 64'hE0F075});

        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        check("prnscr", bus.ps2_key, {1'b0, 64'hE012E07C});

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause", bus.ps2_key, {1'b1, 64'hE11477E1F014F077});
        check("pause_cnt", 65'(n_strobe), 65'd5);

        send_bits(8'h1C, 1'b1, 11);
        check("parity_err", 65'(n_err), 65'd1);
        check("parity_nostrobe", 65'(n_strobe), 65'd5);
        send(8'h29);
        check("after_parity", bus.ps2_key, {1'b0, 64'h29});

        send_bits(8'h1C, 1'b0, 5);
        check("partial_bits", {61'h0, dut.r_bit_cnt}, 65'd5);
        cycles(TIMEOUT + 50);
        check("timeout_err", 65'(n_err), 65'd2);
        check("timeout_bitcnt", {61'h0, dut.r_bit_cnt}, 65'd0);
        send(8'h1C);
        check("after_timeout", bus.ps2_key, {1'b1, 64'h1C});

        send(8'hAA);
        check("ignored_byte", 65'(n_strobe), 65'd7);

        bus.ps2_clk = 1'b0;
        cycles(1);
        bus.ps2_clk = 1'b1;
        cycles(30);
        check("glitch_bitcnt", {61'h0, dut.r_bit_cnt}, 65'd0);
        check("glitch_noerr", 65'(n_err), 65'd2);

        send(8'hE0);
        rst_n = 1'b0;
        cycles(3);
        check("midreset_key", bus.ps2_key, 65'h0);
        check("midreset_outs", {63'h0, bus.key_strobe, bus.rx_err}, 65'h0);
        rst_n = 1'b1;
        cycles(20);
        send(8'h75);
        check("post_reset_key", bus.ps2_key, {1'b1, 64'h75});
        check("final_cnt", 65'(n_strobe), 65'd8);
        check("no_double_strobe", 65'(n_double), 65'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_key_assembler.md
# ps2_key_assembler

Converts the raw PS/2 keyboard serial lines into the 65-bit `ps2_key` event word that the core-side key decoders consume. Internal stages:
- a filtered serial frame receiver;
- a scan-code sequence state machine that groups multi-byte make/break sequences (E0, F0, E1, print-screen) into one event;
- an event register that flips bit 64 once per completed sequence.

It sits between the keyboard pins and the emu-level key handler, and is a drop-in source for `ps2_key`.

## Interface
Parameters:
- `FILTER`, 8: consecutive identical synchronized samples required before the filtered ps2_clk/ps2_data level changes.
- `TIMEOUT`, 50000: clk_sys cycles without a filtered ps2_clk falling edge before a partial frame is discarded.

Ports:
- `clk_sys`  in  1  system clock; all logic is in this single domain.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw keyboard clock line, asynchronous.
- `ps2_data`  in  1  raw keyboard data line, asynchronous.
- `ps2_key`  out  65  event word:
  - [7:0] newest byte of the sequence, [15:8] the byte before it, and so on up to [63:56];
  - unused upper bytes are 0;
  - [64] toggles once per event.
- `key_strobe`  out  1  one-cycle pulse in the same cycle that ps2_key[64] toggles.
- `rx_err`  out  1  one-cycle pulse on a parity, start, stop or timeout error.

## Operation
- **Input conditioning:** 2-flop synchronizer on both lines. Each synchronized line then goes through a saturating counter filter of length FILTER. A falling edge is detected on the filtered clock.
- **Frame reception:** 11 bits sampled from filtered ps2_data, one on each filtered ps2_clk falling edge: start (0), 8 data bits LSB first, odd parity, stop (1).
  - Bit counter runs 0..10.
  - Bad start bit: drop the frame immediately, pulse rx_err, and do not count that edge as a bit.
  - Bad parity or bad stop bit at bit 10: drop the byte and pulse rx_err.
- **Timeout:** counter is cleared on every filtered falling edge and saturates at TIMEOUT. Reaching TIMEOUT while the bit counter is nonzero:
  - clear the bit counter;
  - pulse rx_err;
  - return the assembler to IDLE and clear its shift buffer.
- **Assembler:** 64-bit shift buffer; each accepted byte shifts in at [7:0]. States and transitions:
  - IDLE:
    - E0 → EXT
    - F0 → BRK
    - E1 → PAUSE with remaining=7
    - AA/FA/FE/EE/00/FF → ignored (buffer cleared, no event)
    - any other byte → EMIT
  - EXT:
    - F0 → EXTBRK
    - 12 → PRNMK
    - any other byte → EMIT
  - BRK: any byte → EMIT.
  - EXTBRK:
    - 7C → PRNBK
    - any other byte → EMIT
  - PRNMK: waits for E0 → PRNMK2. A following 7C → EMIT (word E0_12_E0_7C). Any other byte → EMIT as a plain sequence.
  - PRNBK: expects E0, F0, 12 in turn, then EMIT (word E0_F0_7C_E0_F0_12). A mismatch → EMIT what has been collected.
  - PAUSE: decrement remaining on each byte; on reaching 0 → EMIT (word E1_14_77_E1_F0_14_F0_77).
  - EMIT:
    - ps2_key[63:0] ← buffer;
    - ps2_key[64] inverted;
    - key_strobe=1;
    - buffer cleared;
    - → IDLE.
- **Resulting layout:** a plain release is {F0,code} and an extended release is {E0,F0,code}. PRNSCR and PAUSE words are nonzero in [63:24], which matches the downstream filter.
- **Errors:** an error pulse (parity, start, stop or timeout) aborts any in-progress sequence back to IDLE with a cleared buffer.

## Timing
- **Reset values:** while RESET_N=0, all outputs are 0:
  - ps2_key=65'h0, key_strobe=0, rx_err=0;
  - FSM is in IDLE, bit counter=0;
  - filter outputs are 1 (idle bus).
- **Reset mid-frame or mid-sequence:** discards everything. The first event after release has ps2_key[64]=1.
- **Latency:** the filtered falling edge for the stop bit is cycle N.
  - Byte valid / error at N+1.
  - ps2_key and key_strobe update at N+2 when the byte completes a sequence.
  - rx_err pulses at N+1.
- **Hold:** ps2_key holds its value between events; only the toggle signals a new event.
- **Minimum spacing:** two events are at least one full frame apart, so key_strobe never fires on consecutive cycles.

## Test plan
- **Plain make/break:** frames 1C, F0, 1C → two key_strobe pulses:
  - first event: ps2_key[63:0]=0x1C, bit64=1;
  - second event: ps2_key[63:0]=0xF01C, bit64=0.
- **Extended release:** E0, F0, 75 → one event with ps2_key[23:0]=0xE0F075 and [63:24]=0.
- **Print screen and pause:**
  - E0 12 E0 7C → single event with ps2_key[31:0]=0xE012E07C;
  - E1 14 77 E1 F0 14 F0 77 → single event with ps2_key[63:0]=0xE11477E1F014F077.
- **Parity error:** frame 1C with even parity → rx_err pulse, no strobe. A following valid 29 → event 0x29.
- **Timeout:** stop the clock after 5 bits and wait TIMEOUT cycles → rx_err pulse, bit counter back to 0. A subsequent full frame 1C decodes correctly.
- **Glitch and reset:**
  - a 1-cycle low glitch on ps2_clk (shorter than FILTER) produces no bit;
  - asserting RESET_N=0 between E0 and 75 → all outputs 0; after release, frame 75 alone yields 0x75 with bit64=1.
